ritc_train_sequencer: RTL and testbench

- Autonomous RITC input-alignment controller in the GLITCBUS RITC-control space (0x30-0x3F, shadowed at 0x70).
- Per RITC, it asserts TRAIN, scans every IDELAY tap of every data bit, and queries the datapath pattern checker at each tap.
- It programs each bit's delay to the centre of its longest passing window.
- Sequences the datapath delay and check resources through req/ack handshakes; one clock domain, the GLITCBUS clock.

---
 rtl/ritc_train_sequencer_pkg.sv | 44 ++++
 rtl/ritc_train_sequencer_if.sv | 33 +++
 rtl/ritc_train_sequencer_eye.sv | 56 +++++
 rtl/ritc_train_sequencer.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_ritc_train_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ritc_train_sequencer_pkg.sv
// rtl/ritc_train_sequencer_pkg.sv - shared constants, state encoding and result type for the RITC train sequencer
package ritc_train_sequencer_pkg;

    localparam int NTAPS      = 32;
    localparam int NCHAN      = 6;
    localparam int NBITS      = 12;
    localparam int TIMEOUT    = 1024;
    localparam int DEF_SETTLE = 16;
    localparam int NRES       = NCHAN * NBITS;

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_SETTLE = 4'd1;
    localparam logic [3:0] ADDR_RSEL   = 4'd2;
    localparam logic [3:0] ADDR_RESULT = 4'd3;

    localparam int CTRL_START   = 0;
    localparam int CTRL_ABORT   = 1;
    localparam int CTRL_MASK_LO = 8;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_TRAIN  = 4'd1;
    localparam logic [3:0] S_SETTAP = 4'd2;
    localparam logic [3:0] S_SETTLE = 4'd3;
    localparam logic [3:0] S_CHECK  = 4'd4;
    localparam logic [3:0] S_EVAL   = 4'd5;
    localparam logic [3:0] S_PROG   = 4'd6;
    localparam logic [3:0] S_NEXT   = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;
    localparam logic [3:0] S_ERR    = 4'd9;

    typedef struct packed {
        logic       fail;
        logic [5:0] len;
        logic [4:0] centre;
    } result_t;

    // Centre of a window; lower of the two middle taps for even lengths.
    function automatic logic [4:0] window_centre(input logic [4:0] start, input logic [5:0] len);
        logic [4:0] half;
        half = 5'((len - 6'd1) >> 1);
        return (len == 6'd0) ? 5'd0 : start + half;
    endfunction

endpackage

// File: rtl/ritc_train_sequencer_if.sv
// rtl/ritc_train_sequencer_if.sv - register bus and datapath delay/check handshake bundle
interface ritc_train_sequencer_if;
    logic        user_sel_i;
    logic [3:0]  user_addr_i;
    logic        user_wr_i;
    logic        user_rd_i;
    logic [31:0] user_dat_i;
    logic [31:0] user_dat_o;
    logic [1:0]  train_o;
    logic        dly_req_o;
    logic [2:0]  dly_chan_o;
    logic [3:0]  dly_bit_o;
    logic [4:0]  dly_tap_o;
    logic        dly_ack_i;
    logic        chk_req_o;
    logic        chk_ack_i;
    logic        chk_ok_i;
    logic        busy_o;

    modport slave (
        input  user_sel_i, user_addr_i, user_wr_i, user_rd_i, user_dat_i,
        input  dly_ack_i, chk_ack_i, chk_ok_i,
        output user_dat_o, train_o, dly_req_o, dly_chan_o, dly_bit_o, dly_tap_o,
        output chk_req_o, busy_o
    );

    modport master (
        output user_sel_i, user_addr_i, user_wr_i, user_rd_i, user_dat_i,
        output dly_ack_i, chk_ack_i, chk_ok_i,
        input  user_dat_o, train_o, dly_req_o, dly_chan_o, dly_bit_o, dly_tap_o,
        input  chk_req_o, busy_o
    );
endinterface

// File: rtl/ritc_train_sequencer_eye.sv
// rtl/ritc_train_sequencer_eye.sv - longest passing run tracker over one tap scan
module ritc_eye_window
    import ritc_train_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       smp,
    input  logic       ok,
    input  logic       last,
    output logic [5:0] len,
    output logic [4:0] centre
);

    logic [4:0] pos;
    logic [4:0] cur_start;
    logic [5:0] cur_len;
    logic [4:0] best_start;
    logic [5:0] best_len;
    logic [5:0] ext_len;
    logic [4:0] ext_start;

    // Candidate run if the current sample passes.
    always_comb begin
        ext_len   = cur_len + 6'd1;
        ext_start = (cur_len == 6'd0) ? pos : cur_start;
    end

    // Best is promoted while a run grows, so only a strictly longer run replaces it;
    // the run is closed on the last tap so nothing wraps into tap 0.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            pos        <= 5'd0;
            cur_start  <= 5'd0;
            cur_len    <= 6'd0;
            best_start <= 5'd0;
            best_len   <= 6'd0;
        end else if (smp) begin
            pos <= pos + 5'd1;
            if (ok) begin
                cur_len   <= last ? 6'd0 : ext_len;
                cur_start <= ext_start;
                if (ext_len > best_len) begin
                    best_len   <= ext_len;
                    best_start <= ext_start;
                end
            end else begin
                cur_len <= 6'd0;
            end
        end
    end

    assign len    = best_len;
    assign centre = window_centre(best_start, best_len);

endmodule

// File: rtl/ritc_train_sequencer.sv
// rtl/ritc_train_sequencer.sv - RITC input alignment sequencer: tap scan, window centring, result store
module ritc_train_sequencer
    import ritc_train_sequencer_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    ritc_train_sequencer_if.slave   bus
);

    localparam int TMO_W = $clog2(TIMEOUT);

    logic [3:0]       state;
    logic [15:0]      settle;
    logic [1:0]       mask;
    logic [1:0]       run_mask;
    logic [6:0]       rsel;
    logic             rsel_hi;
    logic [2:0]       chan;
    logic [3:0]       bit_idx;
    logic [4:0]       tap;
    logic [4:0]       dly_tap;
    logic [17:0]      cnt;
    logic [TMO_W-1:0] tmo;
    logic [1:0]       train;
    logic             dly_req;
    logic             chk_req;
    logic             done;
    logic             err;
    logic [6:0]       fail_cnt;
    logic             res_fail;
    logic             eye_clr;
    logic [NRES-1:0]  valid;
    result_t          res_mem [NRES];

    logic             wr_ctrl;
    logic             start;
    logic             abort;
    logic [6:0]       idx;
    logic             tmo_hit;
    logic             train_done;
    logic             settle_done;
    logic             smp;
    logic             prog_wr;
    logic [5:0]       eye_len;
    logic [4:0]       eye_centre;
    result_t          rd_res;

    assign wr_ctrl     = bus.user_sel_i && bus.user_wr_i && (bus.user_addr_i == ADDR_CTRL);
    assign start       = wr_ctrl && bus.user_dat_i[CTRL_START];
    assign abort       = wr_ctrl && bus.user_dat_i[CTRL_ABORT];
    assign idx         = {4'd0, chan} * 7'd12 + {3'd0, bit_idx};
    assign tmo_hit     = (tmo == TMO_W'(TIMEOUT - 1));
    assign train_done  = (cnt + 18'd1) >= {settle, 2'b00};
    assign settle_done = (cnt + 18'd1) >= {2'b00, settle};
    assign smp         = (state == S_CHECK) && chk_req && bus.chk_ack_i;
    assign prog_wr     = rst_n_i && !abort && (state == S_PROG) && bus.dly_ack_i;

    ritc_eye_window u_eye (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .clr    (eye_clr),
        .smp    (smp),
        .ok     (bus.chk_ok_i),
        .last   (tap == 5'(NTAPS - 1)),
        .len    (eye_len),
        .centre (eye_centre)
    );

    // Software-writable configuration registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            settle  <= 16'(DEF_SETTLE);
            mask    <= 2'b11;
            rsel    <= 7'd0;
            rsel_hi <= 1'b0;
        end else if (bus.user_sel_i && bus.user_wr_i) begin
            case (bus.user_addr_i)
                ADDR_CTRL:   mask    <= bus.user_dat_i[CTRL_MASK_LO +: 2];
                ADDR_SETTLE: settle  <= bus.user_dat_i[15:0];
                ADDR_RSEL: begin
                    rsel    <= bus.user_dat_i[6:0];
                    rsel_hi <= |bus.user_dat_i[31:7];
                end
                default: ;
            endcase
        end
    end

    // Main sequencer; the mask travelling with START is used so one write both configures and launches.
    always_ff @(posedge clk_i) begin
        eye_clr <= 1'b0;
        if (!rst_n_i) begin
            state    <= S_IDLE;
            run_mask <= 2'b00;
            chan     <= 3'd0;
            bit_idx  <= 4'd0;
            tap      <= 5'd0;
            dly_tap  <= 5'd0;
            cnt      <= 18'd0;
            tmo      <= '0;
            train    <= 2'b00;
            dly_req  <= 1'b0;
            chk_req  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            fail_cnt <= 7'd0;
            res_fail <= 1'b0;
            valid    <= '0;
        end else if (abort && state != S_IDLE) begin
            state   <= S_IDLE;
            dly_req <= 1'b0;
            chk_req <= 1'b0;
            train   <= 2'b00;
            err     <= 1'b1;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (bus.user_dat_i[CTRL_MASK_LO +: 2] == 2'b00) begin
                            done <= 1'b1;
                        end else begin
                            done     <= 1'b0;
                            err      <= 1'b0;
                            fail_cnt <= 7'd0;
                            valid    <= '0;
                            run_mask <= bus.user_dat_i[CTRL_MASK_LO +: 2];
                            chan     <= bus.user_dat_i[CTRL_MASK_LO] ? 3'd0 : 3'd3;
                            bit_idx  <= 4'd0;
                            train    <= bus.user_dat_i[CTRL_MASK_LO] ? 2'b01 : 2'b10;
                            cnt      <= 18'd0;
                            state    <= S_TRAIN;
                        end
                    end
                end
                S_TRAIN: begin
                    if (train_done) begin
                        tap     <= 5'd0;
                        dly_tap <= 5'd0;
                        dly_req <= 1'b1;
                        tmo     <= '0;
                        eye_clr <= 1'b1;
                        state   <= S_SETTAP;
                    end else begin
                        cnt <= cnt + 18'd1;
                    end
                end
                S_SETTAP: begin
                    if (bus.dly_ack_i) begin
                        dly_req <= 1'b0;
                        cnt     <= 18'd0;
                        state   <= S_SETTLE;
                    end else if (tmo_hit) begin
                        dly_req <= 1'b0;
                        state   <= S_ERR;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (settle_done) begin
                        chk_req <= 1'b1;
                        tmo     <= '0;
                        state   <= S_CHECK;
                    end else begin
                        cnt <= cnt + 18'd1;
                    end
                end
                S_CHECK: begin
                    if (bus.chk_ack_i) begin
                        chk_req <= 1'b0;
                        if (tap != 5'(NTAPS - 1)) begin
                            tap     <= tap + 5'd1;
                            dly_tap <= tap + 5'd1;
                            dly_req <= 1'b1;
                            tmo     <= '0;
                            state   <= S_SETTAP;
                        end else begin
                            state <= S_EVAL;
                        end
                    end else if (tmo_hit) begin
                        chk_req <= 1'b0;
                        state   <= S_ERR;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_EVAL: begin
                    res_fail <= (eye_len == 6'd0);
                    if (eye_len == 6'd0)
                        fail_cnt <= fail_cnt + 7'd1;
                    dly_tap <= eye_centre;
                    dly_req <= 1'b1;
                    tmo     <= '0;
                    state   <= S_PROG;
                end
                S_PROG: begin
                    if (bus.dly_ack_i) begin
                        dly_req    <= 1'b0;
                        valid[idx] <= 1'b1;
                        state      <= S_NEXT;
                    end else if (tmo_hit) begin
                        dly_req <= 1'b0;
                        state   <= S_ERR;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (bit_idx != 4'(NBITS - 1)) begin
                        bit_idx <= bit_idx + 4'd1;
                        tap     <= 5'd0;
                        dly_tap <= 5'd0;
                        dly_req <= 1'b1;
                        tmo     <= '0;
                        eye_clr <= 1'b1;
                        state   <= S_SETTAP;
                    end else begin
                        bit_idx <= 4'd0;
                        if (chan == 3'd2 && run_mask[1]) begin
                            chan  <= 3'd3;
                            train <= 2'b10;
                            cnt   <= 18'd0;
                            state <= S_TRAIN;
                        end else if (chan == 3'd2 || chan == 3'd5) begin
                            train <= 2'b00;
                            state <= S_DONE;
                        end else begin
                            chan    <= chan + 3'd1;
                            tap     <= 5'd0;
                            dly_tap <= 5'd0;
                            dly_req <= 1'b1;
                            tmo     <= '0;
                            eye_clr <= 1'b1;
                            state   <= S_SETTAP;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    err   <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    err   <= 1'b1;
                    done  <= 1'b0;
                    train <= 2'b00;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result RAM; validity is tracked separately so a new run clears it in one cycle.
    always_ff @(posedge clk_i) begin
        if (prog_wr)
            res_mem[idx] <= '{fail: res_fail, len: eye_len, centre: eye_centre};
    end

    // Register read mux; unwritten result entries read as zero.
    always_comb begin
        rd_res         = res_mem[0];
        bus.user_dat_o = 32'd0;
        if (!rsel_hi && rsel < 7'(NRES))
            rd_res = res_mem[rsel];
        if (bus.user_sel_i && bus.user_rd_i) begin
            case (bus.user_addr_i)
                ADDR_CTRL:   bus.user_dat_o = {err, done, (state != S_IDLE), 1'b0, state,
                                               1'b0, fail_cnt, 6'd0, mask, 8'd0};
                ADDR_SETTLE: bus.user_dat_o = {16'd0, settle};
                ADDR_RSEL:   bus.user_dat_o = {25'd0, rsel};
                ADDR_RESULT: begin
                    if (!rsel_hi && rsel < 7'(NRES) && valid[rsel])
                        bus.user_dat_o = {1'b1, rd_res.fail, 16'd0, rd_res.len, 3'd0, rd_res.centre};
                end
                default:     bus.user_dat_o = 32'd0;
            endcase
        end
    end

    assign bus.train_o    = train;
    assign bus.dly_req_o  = dly_req;
    assign bus.dly_chan_o = chan;
    assign bus.dly_bit_o  = bit_idx;
    assign bus.dly_tap_o  = dly_tap;
    assign bus.chk_req_o  = chk_req;
    assign bus.busy_o     = (state != S_IDLE);

endmodule

// File: tb/tb_ritc_train_sequencer.sv
// tb/tb_ritc_train_sequencer.sv - self-checking bench for ritc_train_sequencer
module tb_ritc_train_sequencer;

    localparam int A_CTRL = 0, A_SETTLE = 1, A_RSEL = 2, A_RESULT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ritc_train_sequencer_if bus();

    ritc_train_sequencer dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int          total = 0;
    int          passed = 0;
    logic [31:0] pat [72];
    int          cur_tap [72];
    int          prog_tap [72];
    bit          dly_en = 1'b1;
    bit          train1_seen = 1'b0;
    int          dly_wait = 0;
    int          chk_wait = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed = passed + 1;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: longest run of ones in the tap pattern, lowest start on ties, no wrap.
    task automatic model(input logic [31:0] p, output int blen, output int bctr);
        int bs;
        int l;
        blen = 0;
        bs = 0;
        for (int s = 0; s < 32; s++) begin
            l = 0;
            while (s + l < 32 && p[s + l]) l++;
            if (l > blen) begin
                blen = l;
                bs = s;
            end
        end
        bctr = (blen == 0) ? 0 : bs + (blen - 1) / 2;
    endtask

    function automatic logic [31:0] win(input int lo, input int hi);
        logic [31:0] m;
        m = 32'd0;
        for (int t = lo; t <= hi; t++) m[t] = 1'b1;
        return m;
    endfunction

    // Datapath model: acks after 0-2 cycles, answers checks from the per-bit pattern.
    initial begin
        int i;
        bus.dly_ack_i = 1'b0;
        bus.chk_ack_i = 1'b0;
        bus.chk_ok_i  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.dly_ack_i = 1'b0;
            bus.chk_ack_i = 1'b0;
            bus.chk_ok_i  = 1'b0;
            if (bus.train_o[1]) train1_seen = 1'b1;
            if (bus.dly_req_o && dly_en) begin
                if (dly_wait == 0) begin
                    i = int'(bus.dly_chan_o) * 12 + int'(bus.dly_bit_o);
                    cur_tap[i] = int'(bus.dly_tap_o);
                    prog_tap[i] = int'(bus.dly_tap_o);
                    bus.dly_ack_i = 1'b1;
                    dly_wait = $urandom_range(0, 2);
                end else begin
                    dly_wait--;
                end
            end
            if (bus.chk_req_o) begin
                if (chk_wait == 0) begin
                    i = int'(bus.dly_chan_o) * 12 + int'(bus.dly_bit_o);
                    bus.chk_ok_i = pat[i][cur_tap[i]];
                    bus.chk_ack_i = 1'b1;
                    chk_wait = $urandom_range(0, 2);
                end else begin
                    chk_wait--;
                end
            end
        end
    end

    task automatic wr(input int a, input logic [31:0] d);
        @(negedge clk);
        bus.user_sel_i  = 1'b1;
        bus.user_wr_i   = 1'b1;
        bus.user_addr_i = 4'(a);
        bus.user_dat_i  = d;
        @(negedge clk);
        bus.user_sel_i  = 1'b0;
        bus.user_wr_i   = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        bus.user_addr_i = 4'(a);
        bus.user_sel_i  = 1'b1;
        bus.user_rd_i   = 1'b1;
        #1;
        d = bus.user_dat_o;
        bus.user_sel_i  = 1'b0;
        bus.user_rd_i   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (bus.busy_o && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_finished"}, 32'(bus.busy_o), 32'd0);
    endtask

    task automatic wait_chan(input int ch, input int budget, input string tag);
        int n;
        n = 0;
        while (int'(bus.dly_chan_o) != ch && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_reached"}, 32'(bus.dly_chan_o), 32'(ch));
    endtask

    task automatic check_results(input int lo, input int hi, output int nfail);
        logic [31:0] d;
        logic [31:0] exp;
        int blen;
        int bctr;
        nfail = 0;
        for (int i = lo; i <= hi; i++) begin
            model(pat[i], blen, bctr);
            if (blen == 0) nfail++;
            exp = 32'h8000_0000 | ((blen == 0) ? 32'h4000_0000 : 32'd0) | 32'(blen << 8) | 32'(bctr);
            wr(A_RSEL, 32'(i));
            rd(A_RESULT, d);
            check($sformatf("result[%0d]", i), d, exp);
            check($sformatf("prog_tap[%0d]", i), 32'(prog_tap[i]), 32'(bctr));
        end
    endtask

    initial begin
        logic [31:0] d;
        int nf;
        int n;
        bus.user_sel_i  = 1'b0;
        bus.user_wr_i   = 1'b0;
        bus.user_rd_i   = 1'b0;
        bus.user_addr_i = 4'd0;
        bus.user_dat_i  = 32'd0;
        for (int i = 0; i < 72; i++) begin
            cur_tap[i] = 0;
            prog_tap[i] = -1;
            pat[i] = 32'd0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_train", 32'(bus.train_o), 32'd0);
        check("rst_dly_req", 32'(bus.dly_req_o), 32'd0);
        check("rst_chk_req", 32'(bus.chk_req_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(A_CTRL, d);
        check("rst_ctrl", d, 32'h0000_0300);
        rd(A_SETTLE, d);
        check("rst_settle", d, 32'd16);
        rd(A_RESULT, d);
        check("rst_result", d, 32'd0);

        // START with empty mask completes at once
        wr(A_CTRL, 32'h0000_0001);
        check("mask0_busy", 32'(bus.busy_o), 32'd0);
        rd(A_CTRL, d);
        check("mask0_ctrl", d, 32'h4000_0000);

        // Run 1: RITC0, every bit passes 10-19
        for (int i = 0; i < 72; i++) pat[i] = win(10, 19);
        wr(A_SETTLE, 32'd4);
        wr(A_CTRL, 32'h0000_0101);
        check("run1_busy", 32'(bus.busy_o), 32'd1);
        wait_idle(25000, "run1");
        rd(A_CTRL, d);
        check("run1_ctrl", d, 32'h4000_0100);
        check("run1_train1_never", 32'(train1_seen), 32'd0);
        check_results(0, 35, nf);
        wr(A_RSEL, 32'd36);
        rd(A_RESULT, d);
        check("run1_result36_invalid", d, 32'd0);
        wr(A_RSEL, 32'd72);
        rd(A_RESULT, d);
        check("rsel72_reads0", d, 32'd0);
        wr(A_RSEL, 32'd128);
        rd(A_RESULT, d);
        check("rsel128_reads0", d, 32'd0);

        // Run 2: directed windows on bits 0-4, random on the rest, settle 0
        for (int i = 0; i < 72; i++) pat[i] = $urandom;
        pat[0] = win(2, 5) | win(20, 25);
        pat[1] = win(3, 6) | win(20, 23);
        pat[2] = win(28, 31);
        pat[3] = 32'd0;
        pat[4] = 32'hFFFF_FFFF;
        wr(A_SETTLE, 32'd0);
        wr(A_CTRL, 32'h0000_0101);
        wait_idle(20000, "run2");
        check_results(0, 35, nf);
        rd(A_CTRL, d);
        check("run2_ctrl", d, 32'h4000_0100 | 32'(nf << 16));
        wr(A_RSEL, 32'd0);
        rd(A_RESULT, d);
        check("two_runs_longer_wins", d, 32'h8000_0616);
        wr(A_RSEL, 32'd1);
        rd(A_RESULT, d);
        check("equal_runs_lowest", d, 32'h8000_0404);
        wr(A_RSEL, 32'd2);
        rd(A_RESULT, d);
        check("end_of_scan_run", d, 32'h8000_041D);
        wr(A_RSEL, 32'd3);
        rd(A_RESULT, d);
        check("all_fail_bit", d, 32'hC000_0000);
        wr(A_RSEL, 32'd4);
        rd(A_RESULT, d);
        check("all_pass_bit", d, 32'h8000_200F);

        // Delay write never acknowledged -> timeout
        dly_en = 1'b0;
        wr(A_CTRL, 32'h0000_0101);
        n = 0;
        while (!bus.dly_req_o && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tmo_req_seen", 32'(bus.dly_req_o), 32'd1);
        n = 0;
        while (bus.busy_o && n < 1200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tmo_cycles_in_range", 32'(n >= 1020 && n <= 1030), 32'd1);
        rd(A_CTRL, d);
        check("tmo_ctrl", d, 32'h8000_0100);
        check("tmo_train", 32'(bus.train_o), 32'd0);
        check("tmo_dly_req", 32'(bus.dly_req_o), 32'd0);
        dly_en = 1'b1;

        // ABORT mid channel 4, then a full 72-bit scan with an ignored second START
        for (int i = 0; i < 72; i++) pat[i] = $urandom;
        wr(A_SETTLE, 32'd1);
        wr(A_CTRL, 32'h0000_0301);
        wait_chan(4, 30000, "abort_scan");
        repeat (50) @(posedge clk);
        wr(A_CTRL, 32'h0000_0302);
        check("abort_busy", 32'(bus.busy_o), 32'd0);
        check("abort_train", 32'(bus.train_o), 32'd0);
        check("abort_dly_req", 32'(bus.dly_req_o), 32'd0);
        check("abort_chk_req", 32'(bus.chk_req_o), 32'd0);
        rd(A_CTRL, d);
        check("abort_err_done_busy", 32'(d[31:29]), 32'h4);
        check_results(0, 0, nf);
        wr(A_CTRL, 32'h0000_0301);
        wait_chan(1, 5000, "restart");
        check("restart_busy", 32'(bus.busy_o), 32'd1);
        wr(A_CTRL, 32'h0000_0301);
        wr(A_RSEL, 32'd0);
        rd(A_RESULT, d);
        check("second_start_ignored", 32'(d[31]), 32'd1);
        wait_idle(40000, "full");
        check_results(0, 71, nf);
        rd(A_CTRL, d);
        check("full_ctrl", d, 32'h4000_0300 | 32'(nf << 16));

        // Reset during CHECK
        wr(A_CTRL, 32'h0000_0101);
        n = 0;
        while (!bus.chk_req_o && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_mid_chk_seen", 32'(bus.chk_req_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_busy", 32'(bus.busy_o), 32'd0);
        check("rst_mid_train", 32'(bus.train_o), 32'd0);
        check("rst_mid_chk_req", 32'(bus.chk_req_o), 32'd0);
        check("rst_mid_dly_req", 32'(bus.dly_req_o), 32'd0);
        rd(A_CTRL, d);
        check("rst_mid_ctrl", d, 32'h0000_0300);
        @(negedge clk);
        rst_n = 1'b1;
        rd(A_SETTLE, d);
        check("rst_mid_settle", d, 32'd16);
        rd(A_RESULT, d);
        check("rst_mid_result", d, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
